// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the rr_mux channel multiplexer.
package rr_mux_pkg;

   localparam int unsigned MODE_SEL  = 0;
   localparam int unsigned MODE_PRIO = 1;
   localparam int unsigned MODE_RR   = 2;

   // Index width for n channels; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic: external select, fixed priority or round-robin.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = MODE_RR,
   parameter int unsigned SELW     = sel_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] in_valid,
   input  logic [SELW-1:0]     rr_ptr,
   input  logic [SELW-1:0]     sel,
   output logic [CHANNELS-1:0] grant_c,
   output logic [SELW-1:0]     idx_c
);

   logic [CHANNELS-1:0] sel_grant_c;
   logic [CHANNELS-1:0] prio_grant_c;
   logic [CHANNELS-1:0] rr_grant_c;
   logic [SELW-1:0]     sel_idx_c;
   logic [SELW-1:0]     prio_idx_c;
   logic [SELW-1:0]     rr_idx_c;
   logic                prio_found_c;
   logic                rr_found_c;
   logic [SELW-1:0]     rr_pos_c;

   // External select: an out-of-range sel matches no channel and grants nothing.
   always_comb begin
      sel_grant_c = '0;
      sel_idx_c   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (SELW'(i) == sel && in_valid[i]) begin
            sel_grant_c[i] = 1'b1;
            sel_idx_c      = SELW'(i);
         end
      end
   end

   // Fixed priority: lowest valid index wins.
   always_comb begin
      prio_grant_c = '0;
      prio_idx_c   = '0;
      prio_found_c = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!prio_found_c && in_valid[i]) begin
            prio_grant_c[i] = 1'b1;
            prio_idx_c      = SELW'(i);
            prio_found_c    = 1'b1;
         end
      end
   end

   // Round-robin: first valid channel at or after rr_ptr, wrapping modulo CHANNELS.
   always_comb begin
      rr_grant_c = '0;
      rr_idx_c   = '0;
      rr_found_c = 1'b0;
      rr_pos_c   = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         rr_pos_c = SELW'((int'(rr_ptr) + k) % CHANNELS);
         if (!rr_found_c && in_valid[rr_pos_c]) begin
            rr_grant_c[rr_pos_c] = 1'b1;
            rr_idx_c             = rr_pos_c;
            rr_found_c           = 1'b1;
         end
      end
   end

   // Pick the scheme selected by MODE; the unused ones are trimmed in synthesis.
   always_comb begin
      grant_c = rr_grant_c;
      idx_c   = rr_idx_c;
      if (MODE == MODE_SEL) begin
         grant_c = sel_grant_c;
         idx_c   = sel_idx_c;
      end else if (MODE == MODE_PRIO) begin
         grant_c = prio_grant_c;
         idx_c   = prio_idx_c;
      end
   end

endmodule

// File: rtl/rr_mux.sv
// Registered N:1 valid/ready multiplexer with a single-entry output slice.
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = MODE_RR,
   parameter int unsigned SELW     = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [CHANNELS-1:0] grant_c;
   logic [SELW-1:0]     gidx_c;
   logic [SELW-1:0]     rr_ptr;
   logic [SELW-1:0]     rr_ptr_nxt_c;
   logic                load_en_c;
   logic                xfer_c;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .MODE     (MODE),
      .SELW     (SELW)
   ) u_arb (
      .in_valid (in_valid),
      .rr_ptr   (rr_ptr),
      .sel      (sel),
      .grant_c  (grant_c),
      .idx_c    (gidx_c)
   );

   // Ready gating: the slice loads when empty or draining; nothing is accepted in reset.
   always_comb begin
      load_en_c = !out_valid || out_ready;
      in_ready  = '0;
      if (!rst && load_en_c) begin
         in_ready = grant_c;
      end
      xfer_c = |in_ready;
   end

   // Pointer moves past the granted channel, wrapping at the last one.
   always_comb begin
      rr_ptr_nxt_c = gidx_c + SELW'(1);
      if (gidx_c == SELW'(CHANNELS - 1)) begin
         rr_ptr_nxt_c = '0;
      end
   end

   // Output register slice: a new word replaces the old one without a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
      end else if (xfer_c) begin
         out_data  <= in_data[gidx_c*WIDTH +: WIDTH];
         out_chan  <= gidx_c;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer advances only on an accepted input word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (MODE == MODE_RR && xfer_c) begin
         rr_ptr <= rr_ptr_nxt_c;
      end
   end

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux: four instances (RR, priority, select x4, select x3)
// share one randomized stimulus stream and are checked against a queue-based model.
module tb_rr_mux;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [1:0]  sel;
   logic        out_ready;

   logic [3:0]  ir [4];
   logic [2:0]  ir3;
   logic [7:0]  od [4];
   logic [1:0]  oc [4];
   logic        ov [4];

   localparam int MODES [4] = '{2, 1, 0, 0};
   localparam int NCH   [4] = '{4, 4, 4, 3};

   int tests = 0;
   int fails = 0;

   int         ov_m  [4];
   int         ptr_m [4];
   logic [9:0] exp_q [4][$];
   logic [9:0] log0  [$];

   rr_mux #(.WIDTH(8), .CHANNELS(4), .MODE(2)) u_rr (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
      .sel(sel), .out_data(od[0]), .out_chan(oc[0]), .out_valid(ov[0]), .out_ready(out_ready));

   rr_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_prio (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
      .sel(sel), .out_data(od[1]), .out_chan(oc[1]), .out_valid(ov[1]), .out_ready(out_ready));

   rr_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_sel4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
      .sel(sel), .out_data(od[2]), .out_chan(oc[2]), .out_valid(ov[2]), .out_ready(out_ready));

   rr_mux #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_sel3 (
      .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(ir3),
      .sel(sel), .out_data(od[3]), .out_chan(oc[3]), .out_valid(ov[3]), .out_ready(out_ready));

   assign ir[3] = {1'b0, ir3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference grant: returns the granted channel or -1, straight from the selection rules.
   function automatic int ref_grant(input int mode, input int nch, input logic [3:0] v,
                                    input int s, input int ptr);
      if (mode == 0) begin
         if (s < nch && v[s]) return s;
         return -1;
      end
      if (mode == 1) begin
         for (int i = 0; i < nch; i++) if (v[i]) return i;
         return -1;
      end
      for (int k = 0; k < nch; k++) begin
         if (v[(ptr + k) % nch]) return (ptr + k) % nch;
      end
      return -1;
   endfunction

   // One cycle of stimulus, issued #1 after a rising edge; returns #1 after the next one.
   task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy,
                       input logic [1:0] s);
      int   g;
      int   load;
      logic [3:0] exp_ir;
      logic [7:0] wd;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      sel       = s;
      #1;
      for (int n = 0; n < 4; n++) begin
         g      = ref_grant(MODES[n], NCH[n], v, int'(s), ptr_m[n]);
         load   = (ov_m[n] == 0 || ordy) ? 1 : 0;
         exp_ir = (load != 0 && g >= 0) ? 4'(1 << g) : 4'h0;
         check($sformatf("in_ready[%0d]", n), 32'(ir[n]), 32'(exp_ir));
         check($sformatf("out_valid[%0d]", n), 32'(ov[n]), 32'(ov_m[n]));
         if (load != 0 && g >= 0) begin
            wd = d[g*8 +: 8];
            exp_q[n].push_back({2'(g), wd});
            ov_m[n] = 1;
            if (MODES[n] == 2) ptr_m[n] = (g + 1) % NCH[n];
         end else if (ordy) begin
            ov_m[n] = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      for (int n = 0; n < 4; n++) begin
         exp_q[n].delete();
         ov_m[n]  = 0;
         ptr_m[n] = 0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int n = 0; n < 4; n++) begin
         check($sformatf("%s in_ready[%0d]", tag, n), 32'(ir[n]), 32'h0);
         check($sformatf("%s out_valid[%0d]", tag, n), 32'(ov[n]), 32'h0);
         check($sformatf("%s out_data[%0d]", tag, n), 32'(od[n]), 32'h0);
      end
   endtask

   // Monitor: every output transfer pops the oldest expected word of that instance.
   always @(negedge clk) begin
      if (!rst) begin
         for (int n = 0; n < 4; n++) begin
            if (ov[n] && out_ready) begin
               if (exp_q[n].size() == 0) begin
                  check($sformatf("unexpected word[%0d]", n), {22'h0, oc[n], od[n]}, 32'hFFFF_FFFF);
               end else begin
                  check($sformatf("word[%0d]", n), {22'h0, oc[n], od[n]},
                        {22'h0, exp_q[n].pop_front()});
               end
               if (n == 0) log0.push_back({oc[0], od[0]});
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 4'hF;
      in_data   = 32'h4433_2211;
      out_ready = 1'b1;
      sel       = 2'd0;
      flush_model();

      // Reset held three cycles with every channel requesting.
      repeat (3) begin
         @(posedge clk);
         #1;
         check_reset_outputs("reset");
      end
      rst = 1'b0;
      log0.delete();

      // Round-robin rotation 0,1,2,3,0 starting from channel 0.
      repeat (6) step(4'hF, 32'h4433_2211, 1'b1, 2'd0);
      check("rotation count", 32'(log0.size()), 32'd5);
      if (log0.size() == 5) begin
         check("rot0", 32'(log0[0]), 32'h011);
         check("rot1", 32'(log0[1]), 32'h122);
         check("rot2", 32'(log0[2]), 32'h233);
         check("rot3", 32'(log0[3]), 32'h344);
         check("rot4", 32'(log0[4]), 32'h011);
      end

      // Backpressure: the word 22 from channel 1 must hold for five cycles.
      repeat (5) step(4'hF, 32'h4433_2211, 1'b0, 2'd0);
      check("bp hold data", 32'(od[0]), 32'h22);
      check("bp hold chan", 32'(oc[0]), 32'd1);
      check("bp hold valid", 32'(ov[0]), 32'd1);
      step(4'hF, 32'h4433_2211, 1'b1, 2'd0);
      check("bp release data", 32'(od[0]), 32'h33);

      // Fixed priority: channel 1 starves channel 3 until it drops.
      repeat (3) step(4'b1010, 32'h4433_2211, 1'b1, 2'd0);
      check("prio chan1", 32'(oc[1]), 32'd1);
      step(4'b1000, 32'h4433_2211, 1'b1, 2'd0);
      check("prio chan3", 32'(oc[1]), 32'd3);
      check("prio data3", 32'(od[1]), 32'h44);

      // External select cases, including an out-of-range select on the 3-channel copy.
      step(4'b0100, 32'h4433_2211, 1'b1, 2'd2);
      check("sel2 chan", 32'(oc[2]), 32'd2);
      check("sel2 chan x3", 32'(oc[3]), 32'd2);
      step(4'b1011, 32'h4433_2211, 1'b1, 2'd2);
      check("sel2 no grant", 32'(ov[2]), 32'd0);
      step(4'b1111, 32'h4433_2211, 1'b1, 2'd3);
      check("sel3 x3 no grant", 32'(ov[3]), 32'd0);
      check("sel3 x4 chan", 32'(oc[2]), 32'd3);

      // Reset while a word is held under backpressure: the word is dropped at once.
      repeat (2) step(4'h0, 32'h0, 1'b1, 2'd0);
      repeat (2) step(4'hF, 32'hA5B6_C7D8, 1'b0, 2'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid reset");
      flush_model();
      @(posedge clk);
      #1;
      check_reset_outputs("mid reset hold");
      rst = 1'b0;

      // Randomized traffic with random backpressure and select.
      for (int it = 0; it < 400; it++) begin
         step(4'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)));
      end

      // Drain and confirm every accepted word came out.
      repeat (3) step(4'h0, 32'h0, 1'b1, 2'd0);
      for (int n = 0; n < 4; n++) begin
         check($sformatf("leftover[%0d]", n), 32'(exp_q[n].size()), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
